// File: rtl/execute_cycle_pkg.sv
// Shared encodings for the RV32I execute stage: ALU operations, forwarding
// selects, result-source codes and branch funct3 values.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_MUL  = 4'b1010
  } alu_op_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational RV32I ALU. Optional multiplier on op 1010 when EXEC_MUL_EN
// is defined; otherwise that code returns 0 and no multiplier exists.
import riscv_pkg::*;

module alu_unit #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      alu_ctrl_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // operation select; unlisted codes produce 0
  always_comb begin
    result_o = '0;
    case (alu_ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
`ifdef EXEC_MUL_EN
      ALU_MUL:  result_o = a_i * b_i;
`endif
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and
// the EX/MEM pipeline register. Build option: EXEC_MUL_EN adds MUL (op 1010).
import riscv_pkg::*;

module execute_cycle #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC_TARGET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic            ALUSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            EnM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM_out
);

  logic [XLEN-1:0] src_a, write_data, src_b;
  logic [XLEN-1:0] alu_result, jalr_sum, pc_target;
  logic            alu_zero_unused;
  logic            branch_taken;

  logic            reg_write_q, reg_write_d;
  logic            mem_write_q, mem_write_d;
  logic [1:0]      result_src_q, result_src_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;

  // operand forwarding; 11 falls back to the register-file value
  always_comb begin
    src_a = RD1_E;
    case (ForwardAE)
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = alu_result_q;
      default: src_a = RD1_E;
    endcase
    write_data = RD2_E;
    case (ForwardBE)
      FWD_W:   write_data = ResultW;
      FWD_M:   write_data = alu_result_q;
      default: write_data = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : write_data;

  alu_unit #(.XLEN(XLEN)) u_alu (
    .a_i        (src_a),
    .b_i        (src_b),
    .alu_ctrl_i (ALUControlE),
    .result_o   (alu_result),
    .zero_o     (alu_zero_unused)
  );

  // branch condition straight from the operands, independent of ALU op
  always_comb begin
    branch_taken = 1'b0;
    case (Funct3E)
      F3_BEQ:  branch_taken = (src_a == src_b);
      F3_BNE:  branch_taken = (src_a != src_b);
      F3_BLT:  branch_taken = ($signed(src_a) <  $signed(src_b));
      F3_BGE:  branch_taken = ($signed(src_a) >= $signed(src_b));
      F3_BLTU: branch_taken = (src_a <  src_b);
      F3_BGEU: branch_taken = (src_a >= src_b);
      default: branch_taken = 1'b0;
    endcase
  end

  assign jalr_sum  = src_a + Imm_Ext_E;
  assign pc_target = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + Imm_Ext_E);
  assign PCSrcE    = JumpE | (BranchE & branch_taken);
  assign PCTargetE = rst ? RESET_PC_TARGET : pc_target;

  // EX/MEM next state: load when enabled, otherwise hold
  always_comb begin
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    rd_d         = rd_q;
    pc_plus4_d   = pc_plus4_q;
    write_data_d = write_data_q;
    alu_result_d = alu_result_q;
    if (EnM) begin
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
      rd_d         = RD_E;
      pc_plus4_d   = PCPlus4E;
      write_data_d = write_data;
      alu_result_d = alu_result;
    end
  end

  // EX/MEM register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      rd_q         <= 5'd0;
      pc_plus4_q   <= '0;
      write_data_q <= '0;
      alu_result_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      write_data_q <= write_data_d;
      alu_result_q <= alu_result_d;
    end
  end

  assign RegWriteM       = reg_write_q;
  assign MemWriteM       = mem_write_q;
  assign ResultSrcM      = result_src_q;
  assign RD_M            = rd_q;
  assign PCPlus4M        = pc_plus4_q;
  assign WriteDataM      = write_data_q;
  assign ALU_ResultM_out = alu_result_q;

endmodule
